// File: rtl/rtl_piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// rtl_serial_pkg
// Shared definitions for the parallel-in / serial-out serializer slice:
//   SER_WIDTH  : word width and frame length in cycles
//   SER_CNT_W  : width of the in-frame bit index
//   ser_word_t : one parallel word
// -----------------------------------------------------------------------------
package rtl_serial_pkg;

  localparam int SER_WIDTH = 8;
  localparam int SER_CNT_W = $clog2(SER_WIDTH);

  typedef logic [SER_WIDTH-1:0] ser_word_t;

endpackage : rtl_serial_pkg

// File: rtl/rtl_piso_serializer_frame_counter.sv
// -----------------------------------------------------------------------------
// rtl_frame_counter
// Free-running modulo-WIDTH counter that marks frame boundaries.
// Ports:
//   clk           : rising-edge clock
//   rst           : synchronous active-low reset (counter returns to 0)
//   cnt_o         : current bit index within the frame
//   frame_start_o : high while cnt_o == 0 (the next edge loads a new word)
// -----------------------------------------------------------------------------
module rtl_frame_counter
  import rtl_serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic             frame_start_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count logic: wrap explicitly so non-power-of-two widths behave.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_W'(WIDTH - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign frame_start_o = (cnt_q == '0);

endmodule : rtl_frame_counter

// File: rtl/rtl_piso_serializer.sv
// -----------------------------------------------------------------------------
// rtl_piso_serializer
// Captures a WIDTH-bit word at the start of every WIDTH-cycle frame and emits
// it MSB first, one bit per clock, on a registered serial output.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset; aborts the current frame
//   data_in  : parallel word, sampled only on frame-start edges
//   data_out : registered serial bit stream, MSB first
// -----------------------------------------------------------------------------
module rtl_piso_serializer
  import rtl_serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             data_out_q;
  logic             data_out_d;
  logic [CNT_W-1:0] cnt_s;
  logic             frame_start_s;

  rtl_frame_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .cnt_o         (cnt_s),
    .frame_start_o (frame_start_s)
  );

  // Shift datapath: load on frame start, otherwise shift zeros in from the
  // bottom. data_in is only selected on frame start, so its value (even X)
  // between frame starts never reaches the output.
  always_comb begin
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    if (frame_start_s) begin
      data_out_d = data_in[WIDTH-1];
      shreg_d    = {data_in[WIDTH-2:0], 1'b0};
    end else begin
      data_out_d = shreg_q[WIDTH-1];
      shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register and output flop with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q    <= '0;
      data_out_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule : rtl_piso_serializer

// File: tb/tb_rtl_piso_serializer.sv
module tb_rtl_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_out;

  int errors = 0;
  int checks = 0;

  rtl_piso_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run one full frame, comparing each emitted bit with the hand-written
  // expected pattern (MSB first), then check the counter wrapped to 0.
  task automatic run_frame(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_bit($sformatf("%s_bit%0d", tag, k), data_out, exp[7-k]);
    end
    chk_cnt({tag, "_wrap"}, dut.cnt_s, 3'd0);
  endtask

  initial begin
    logic [7:0] exp_mid;
    // Reset hold with all-ones on the input.
    rst     = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bit($sformatf("rst_hold_out%0d", i), data_out, 1'b0);
      chk_cnt($sformatf("rst_hold_cnt%0d", i), dut.cnt_s, 3'd0);
    end

    // Single frame 0xCA -> 1,1,0,0,1,0,1,0.
    rst     = 1'b1;
    data_in = 8'hCA;
    run_frame("frame_CA", 8'b1100_1010);

    // Back-to-back: 0x56 -> 0,1,0,1,0,1,1,0.
    data_in = 8'h56;
    run_frame("frame_56", 8'b0101_0110);

    // Mid-frame input changes (including X) must be ignored.
    data_in = 8'hCA;
    exp_mid = 8'b1100_1010;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_bit($sformatf("mid_bit%0d", k), data_out, exp_mid[7-k]);
      if (k == 1) data_in = 8'h00;
      if (k == 3) data_in = 8'hxx;
      if (k == 5) data_in = 8'h00;
    end
    chk_cnt("mid_wrap", dut.cnt_s, 3'd0);
    run_frame("after_mid_zero", 8'h00);

    // Reset mid-frame: load 0x56, emit 0,1,0, then reset for one edge.
    data_in = 8'h56;
    step(); chk_bit("rstmid_b0", data_out, 1'b0);
    step(); chk_bit("rstmid_b1", data_out, 1'b1);
    step(); chk_bit("rstmid_b2", data_out, 1'b0);
    rst = 1'b0;
    step();
    chk_bit("rstmid_out", data_out, 1'b0);
    chk_cnt("rstmid_cnt", dut.cnt_s, 3'd0);
    rst     = 1'b1;
    data_in = 8'hCA;
    run_frame("post_rst_CA", 8'b1100_1010);

    // Extremes.
    data_in = 8'h80;
    run_frame("frame_80", 8'b1000_0000);
    data_in = 8'hFF;
    run_frame("frame_FF", 8'b1111_1111);
    data_in = 8'h00;
    run_frame("frame_00", 8'b0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rtl_piso_serializer
